// File: rtl/bit_unpacker_if.sv
// Bit unpacker bus: byte input from the decrypt stage, peek window and consume
// request from the Huffman decoder, plus stream status.
interface bit_unpacker_if #(
  parameter int WIN_W = 16
);
  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_data/in_last must hold steady while in_valid waits. consume_en has no
  // ready; an illegal request is dropped and reported on err.
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIN_W-1:0] win_data;
  logic [5:0]       win_count;
  logic             win_valid;
  logic             consume_en;
  logic [4:0]       consume_len;
  logic             done;
  logic             err;

  modport master (
    output in_data, in_valid, in_last, consume_en, consume_len,
    input  in_ready, win_data, win_count, win_valid, done, err
  );

  modport slave (
    input  in_data, in_valid, in_last, consume_en, consume_len,
    output in_ready, win_data, win_count, win_valid, done, err
  );
endinterface

// File: rtl/bit_unpacker.sv
// Repacks plaintext bytes into an MSB-aligned bit reservoir and exposes a peek
// window to the symbol decoder. Define BIT_UNPACKER_LSB_FIRST_EN for LSB-first streams.
module bit_unpacker #(
  parameter int WIN_W = 16,
  parameter int BUF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_unpacker_if.slave     bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TAIL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] WIN_LIM  = 6'(WIN_W);
  localparam logic [5:0] FILL_LIM = 6'(BUF_W - 8);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d, buf_cons, byte_ext;
  logic [5:0]         cnt_q, cnt_d, cnt_cons, len_ext;
  logic               err_q, err_d;
  logic [7:0]         byte_bits;
  logic               ready, accept, consume_ok;

`ifdef BIT_UNPACKER_LSB_FIRST_EN
  always_comb begin
    byte_bits = '0;
    for (int i = 0; i < 8; i++) begin
      byte_bits[i] = bus.in_data[7-i];
    end
  end
`else
  assign byte_bits = bus.in_data;
`endif

  // Consume is applied first; the new byte lands just below the surviving bits.
  always_comb begin
    len_ext    = {1'b0, bus.consume_len};
    ready      = (state_q == ST_RUN) && (cnt_q <= FILL_LIM);
    accept     = bus.in_valid && ready;
    consume_ok = bus.consume_en && (len_ext != 6'd0) &&
                 (len_ext <= WIN_LIM) && (len_ext <= cnt_q);

    buf_cons = buf_q;
    cnt_cons = cnt_q;
    if (consume_ok) begin
      buf_cons = buf_q << bus.consume_len;
      cnt_cons = cnt_q - len_ext;
    end

    byte_ext = {byte_bits, {(BUF_W-8){1'b0}}} >> cnt_cons;
    buf_d    = buf_cons;
    cnt_d    = cnt_cons;
    if (accept) begin
      buf_d = buf_cons | byte_ext;
      cnt_d = cnt_cons + 6'd8;
    end

    err_d = err_q | (bus.consume_en && !consume_ok);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (accept && bus.in_last) state_d = ST_TAIL;
      ST_TAIL: if (cnt_d == 6'd0)         state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Bits below the count are always zero, so the tail window is already padded.
  assign bus.in_ready  = ready;
  assign bus.win_data  = buf_q[BUF_W-1 -: WIN_W];
  assign bus.win_count = cnt_q;
  assign bus.win_valid = (cnt_q >= WIN_LIM) || ((state_q == ST_TAIL) && (cnt_q != 6'd0));
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Self-checking bench for bit_unpacker: bit-queue reference model feeding a
// per-cycle expected-snapshot scoreboard, plus directed value checks.
module tb_bit_unpacker;

  localparam int WIN_W  = 16;
  localparam int BUF_W  = 32;
  localparam int SNAP_W = 26;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  bit_unpacker_if #(.WIN_W(WIN_W)) bus ();

  bit_unpacker #(.WIN_W(WIN_W), .BUF_W(BUF_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model: stream as a queue of bits ----------------
  logic [SNAP_W-1:0] exp_q[$];
  bit                mq[$];
  int                phase;    // 0 accepting, 1 last byte seen, 2 drained
  bit                merr;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic model_reset();
    mq.delete();
    phase = 0;
    merr  = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit l,
                            input bit ce, input logic [4:0] len);
    bit rdy;
    int n;
    rdy = (phase == 0) && (mq.size() <= BUF_W - 8);
    n   = int'(len);
    if (ce) begin
      if (n >= 1 && n <= WIN_W && n <= mq.size()) begin
        for (int i = 0; i < n; i++) void'(mq.pop_front());
      end else begin
        merr = 1'b1;
      end
    end
    if (v && rdy) begin
`ifdef BIT_UNPACKER_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) mq.push_back(d[i]);
`else
      for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
`endif
      if (l) phase = 1;
    end
    if (phase == 1 && mq.size() == 0) phase = 2;
  endtask

  function automatic logic [SNAP_W-1:0] model_snap();
    logic [WIN_W-1:0] w;
    int               sz;
    logic             rdy, vld;
    w   = '0;
    sz  = mq.size();
    for (int i = 0; i < WIN_W; i++) begin
      if (i < sz) w[WIN_W-1-i] = mq[i];
    end
    rdy = (phase == 0) && (sz <= BUF_W - 8);
    vld = (sz >= WIN_W) || (phase == 1 && sz > 0);
    return {rdy, w, 6'(sz), vld, (phase == 2), merr};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [SNAP_W-1:0] act, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.in_ready, bus.win_data, bus.win_count, bus.win_valid, bus.done, bus.err};
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL snapshot t=%0t: actual rdy=%0b win=%h cnt=%0d vld=%0b done=%0b err=%0b, required rdy=%0b win=%h cnt=%0d vld=%0b done=%0b err=%0b",
                   $time, act[25], act[24:9], act[8:3], act[2], act[1], act[0],
                   e[25], e[24:9], e[8:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.in_last     = 1'b0;
    bus.consume_en  = 1'b0;
    bus.consume_len = 5'd0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l,
                      input bit ce, input logic [4:0] len);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_last     = l;
    bus.consume_en  = ce;
    bus.consume_len = len;
    @(posedge clk);
    model_edge(v, d, l, ce, len);
    exp_q.push_back(model_snap());
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic cons(input logic [4:0] len);
    step(1'b0, 8'h00, 1'b0, 1'b1, len);
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    exp_q.push_back(model_snap());
    #1;
    check_lit("reset_err", 32'(bus.err), 32'd0);
    check_lit("reset_cnt", 32'(bus.win_count), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic random_cycle(input bit allow_v);
    bit         v, ce;
    logic [4:0] len;
    v   = allow_v && ($urandom_range(0, 2) != 0);
    ce  = ($urandom_range(0, 3) != 0);
    len = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
    step(v, 8'($urandom_range(0, 255)), 1'b0, ce, len);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (phase != 2 && k < 200) begin
      if (mq.size() == 0) step(1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
      else cons(5'($urandom_range(1, (mq.size() < WIN_W) ? mq.size() : WIN_W)));
      k++;
    end
    check_lit("drain_done", 32'(bus.done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    exp_q.push_back(model_snap());
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // basic append and consume
    push(8'hA5);
    push(8'h3C);
    check_lit("append_cnt", 32'(bus.win_count), 32'd16);
    check_lit("append_vld", 32'(bus.win_valid), 32'd1);
`ifndef BIT_UNPACKER_LSB_FIRST_EN
    check_lit("append_win", 32'(bus.win_data), 32'hA53C);
`endif
    cons(5'd3);
    check_lit("consume3_cnt", 32'(bus.win_count), 32'd13);
`ifndef BIT_UNPACKER_LSB_FIRST_EN
    check_lit("consume3_win", 32'(bus.win_data), 32'h29E0);
`endif
    cons(5'd13);
    check_lit("consume13_cnt", 32'(bus.win_count), 32'd0);
    check_lit("consume13_vld", 32'(bus.win_valid), 32'd0);

    // full backpressure
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    check_lit("full_cnt", 32'(bus.win_count), 32'd32);
    check_lit("full_rdy", 32'(bus.in_ready), 32'd0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 5'd8);
    check_lit("bp_cnt", 32'(bus.win_count), 32'd24);
    check_lit("bp_rdy", 32'(bus.in_ready), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 5'd0);
    check_lit("bp_accept_cnt", 32'(bus.win_count), 32'd32);
    cons(5'd16);
    cons(5'd16);

    // simultaneous consume and append
    push(8'hA5);
    push(8'h3C);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 5'd4);
    check_lit("simul_cnt", 32'(bus.win_count), 32'd20);
`ifndef BIT_UNPACKER_LSB_FIRST_EN
    check_lit("simul_win", 32'(bus.win_data), 32'h53CF);
`endif
    cons(5'd16);
    cons(5'd4);

    // randomized streaming, including illegal consumes
    for (int i = 0; i < 300; i++) random_cycle(1'b1);

    // error flag
    do_reset();
    push(8'hE0);
    cons(5'd3);
    cons(5'd6);
    check_lit("err_set", 32'(bus.err), 32'd1);
    check_lit("err_cnt_hold", 32'(bus.win_count), 32'd5);
    cons(5'd0);
    check_lit("err_sticky", 32'(bus.err), 32'd1);
    cons(5'd20);

    // mid-stream reset
    push(8'h12);
    push(8'h34);
    do_reset();

    // bit order
    push(8'h01);
`ifdef BIT_UNPACKER_LSB_FIRST_EN
    check_lit("order_win", 32'(bus.win_data), 32'h8000);
`else
    check_lit("order_win", 32'(bus.win_data), 32'h0100);
`endif

    // stream tail
    do_reset();
    step(1'b1, 8'h80, 1'b1, 1'b0, 5'd0);
    check_lit("tail_rdy", 32'(bus.in_ready), 32'd0);
    check_lit("tail_vld", 32'(bus.win_valid), 32'd1);
    check_lit("tail_cnt", 32'(bus.win_count), 32'd8);
`ifndef BIT_UNPACKER_LSB_FIRST_EN
    check_lit("tail_win", 32'(bus.win_data), 32'h8000);
`endif
    cons(5'd8);
    check_lit("tail_done", 32'(bus.done), 32'd1);
    push(8'h55);
    push(8'hAA);
    check_lit("done_ignores_cnt", 32'(bus.win_count), 32'd0);

    // random stream ending with a last byte, then drain
    do_reset();
    for (int i = 0; i < 60; i++) random_cycle(1'b1);
    for (int k = 0; k < 50 && phase == 0; k++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1, (mq.size() >= 8), 5'd8);
    end
    for (int i = 0; i < 5; i++) random_cycle(1'b1);
    drain();
    for (int i = 0; i < 4; i++) random_cycle(1'b1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual run still active, required finish before 200000");
    $fatal(1);
  end

endmodule
